// File: rtl/seg7_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder:
// active-low segment patterns (a..g) and FSM encoding.
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    WAIT_CHANGE = 2'd0,
    SETTLING    = 2'd1,
    CAPTURED    = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup: active-low segment pattern to
// hex nibble, with blank and invalid flags.
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pat)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex value shown on a multiplexed 7-segment
// display by sampling its segment and anode lines.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [6:0]              out7_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    err_seg,
  output logic                    err_en
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] ONE = 1;

  logic [6:0]            seg_q, seg_d;
  logic [6:0]            pseg_q, pseg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [NUM_DIGITS-1:0] pen_q, pen_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] sblank_q, sblank_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [VW-1:0]         value_q, value_d;
  logic [NUM_DIGITS-1:0] bmask_q, bmask_d;
  logic                  fv_q, fv_d;
  logic                  eseg_q, eseg_d;
  logic                  een_q, een_d;
  logic                  done_q, done_d;

  logic                  changed;
  logic                  capture;
  logic [NUM_DIGITS-1:0] an;
  logic [3:0]            dec_nib;
  logic                  dec_blank;
  logic                  dec_inv;

  seg7_pattern_decode u_dec (
    .pat     (seg_q),
    .nibble  (dec_nib),
    .blank   (dec_blank),
    .invalid (dec_inv)
  );

  assign an = ~en_q;

  always_comb begin
    seg_d    = out7_in;
    en_d     = en_in;
    pseg_d   = seg_q;
    pen_d    = en_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    shadow_d = shadow_q;
    sblank_d = sblank_q;
    seen_d   = seen_q;
    value_d  = value_q;
    bmask_d  = bmask_q;
    fv_d     = 1'b0;
    eseg_d   = 1'b0;
    een_d    = 1'b0;
    done_d   = 1'b0;
    capture  = 1'b0;

    changed = (seg_q != pseg_q) || (en_q != pen_q);

    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q < CW'(SETTLE_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      WAIT_CHANGE: begin
        if (changed) state_d = SETTLING;
      end
      SETTLING: begin
        if (!changed && cnt_d == CW'(SETTLE_CYCLES - 1)) begin
          state_d = CAPTURED;
          capture = 1'b1;
        end
      end
      CAPTURED: begin
        if (changed) state_d = SETTLING;
      end
      default: state_d = WAIT_CHANGE;
    endcase

    // Frame load lands one cycle after the completing capture
    if (done_q) begin
      value_d = shadow_q;
      bmask_d = sblank_q;
      fv_d    = 1'b1;
      seen_d  = '0;
    end

    if (capture && an != '0) begin
      if (|(an & (an - ONE))) begin
        een_d = 1'b1;
      end else if (dec_inv) begin
        eseg_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an[i]) begin
            shadow_d[4*i +: 4] = dec_nib;
            sblank_d[i]        = dec_blank;
            seen_d[i]          = 1'b1;
          end
        end
        done_d = &seen_d;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      seg_q    <= '0;
      en_q     <= '0;
      pseg_q   <= '0;
      pen_q    <= '0;
      cnt_q    <= '0;
      state_q  <= WAIT_CHANGE;
      shadow_q <= '0;
      sblank_q <= '0;
      seen_q   <= '0;
      value_q  <= '0;
      bmask_q  <= '0;
      fv_q     <= 1'b0;
      eseg_q   <= 1'b0;
      een_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      en_q     <= en_d;
      pseg_q   <= pseg_d;
      pen_q    <= pen_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sblank_q <= sblank_d;
      seen_q   <= seen_d;
      value_q  <= value_d;
      bmask_q  <= bmask_d;
      fv_q     <= fv_d;
      eseg_q   <= eseg_d;
      een_q    <= een_d;
      done_q   <= done_d;
    end
  end

  assign value       = value_q;
  assign blank_mask  = bmask_q;
  assign frame_valid = fv_q;
  assign err_seg     = eseg_q;
  assign err_en      = een_q;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: consecutive identical input samples required before a digit is captured (legal range 2..255).
REQ-002 Parameter NUM_DIGITS, default 8: number of multiplexed digit positions.
REQ-003 Port Clk, input, 1: single clock for all logic.
REQ-004 Port Rst, input, 1: reset, synchronous and active-high.
REQ-005 Port out7_in, input, 7: segment bus, active-low, bit6=a .. bit0=g.
REQ-006 Port en_in, input, NUM_DIGITS: digit anode enables, active-low, bit i = digit i (nibble i of value).
REQ-007 Port value, output, 4*NUM_DIGITS: last complete decoded frame.
REQ-008 Port frame_valid, output, 1: one-cycle pulse when value updates.
REQ-009 Port blank_mask, output, NUM_DIGITS: digits that were blank (all segments off) in the last frame.
REQ-010 Port err_seg, output, 1: one-cycle pulse, unrecognised segment pattern.
REQ-011 Port err_en, output, 1: one-cycle pulse, more than one anode active.

Function
REQ-012 Inputs SHALL be registered once before any use; all decisions use registered samples.
REQ-013 Stability counter SHALL reset to 0 whenever {out7,en} differs from the previous sample, otherwise increment, saturating at SETTLE_CYCLES.
REQ-014 FSM states: WAIT_CHANGE, SETTLING, CAPTURED.
REQ-015 SETTLING -> CAPTURED when the counter reaches SETTLE_CYCLES-1; the capture action fires exactly once in that cycle.
REQ-016 CAPTURED -> SETTLING on any sample change; WAIT_CHANGE -> SETTLING on any sample change; Rst -> WAIT_CHANGE.
REQ-017 Capture with exactly one anode low: decode segments to a nibble, write shadow[i], set seen[i].
REQ-018 Decode table (active-low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-019 Pattern 1111111 SHALL decode as nibble 0 with the shadow blank bit set; any other pattern outside the table SHALL pulse err_seg and leave shadow[i] and seen[i] unchanged.
REQ-020 Capture with all anodes high SHALL do nothing; with more than one anode low it SHALL pulse err_en and write nothing.
REQ-021 Re-capture of an already-seen digit SHALL overwrite its nibble and blank bit.
REQ-022 When a capture makes seen all ones, the next cycle SHALL load value and blank_mask from the shadow (including that capture), pulse frame_valid, and clear seen.
REQ-023 Latency: input change to frame_valid = 1 (input reg) + SETTLE_CYCLES + 1 cycles for the completing digit.
REQ-024 value and blank_mask SHALL hold between frames; errors do not clear seen.

Reset
REQ-025 Rst SHALL set value=0, blank_mask=0, frame_valid=0, err_seg=0, err_en=0, seen=0, shadow=0, counter=0, state=WAIT_CHANGE.
REQ-026 Rst asserted mid-frame SHALL discard the partial frame; no frame_valid until NUM_DIGITS new captures follow.

Structure
REQ-027 The shared package SHALL hold the 16 segment-pattern constants, the blank pattern and the FSM state encoding.
REQ-028 The pattern lookup SHALL be one combinational sub-module, seg7_pattern_decode (in: 7-bit pattern; out: nibble, blank, invalid).

Verification
REQ-029 Scan digits 0..7 showing 1,2,3,4,5,6,7,8 for 10 cycles each -> one frame_valid, value=32'h87654321, blank_mask=0.
REQ-030 Digit changes every 2 cycles with SETTLE_CYCLES=4 -> no capture, no frame_valid, no errors.
REQ-031 Digit 3 pattern 1111110 within a full scan -> err_seg pulse, no frame_valid until digit 3 is rescanned as 9, then value nibble3=9.
REQ-032 en_in=8'b11110011 held 10 cycles -> single err_en pulse, seen unchanged.
REQ-033 Digit 7 blank in a full scan of 0..6=A..F,0 -> value[31:28]=0, blank_mask=8'h80.
REQ-034 Rst after 5 digits, then a full 8-digit scan -> exactly one frame_valid, after the 8th post-reset capture.
